// File: rtl/psum_drain_pkg.sv
// Shared PE constants and the drain FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package psum_drain_pkg;

  // psum word width, spad address width and spad depth shared with the
  // spad array and the capture-register logic on the fill side
  localparam int PSUM_DATA_WIDTH = 16;
  localparam int PSUM_ADDR_WIDTH = 5;
  localparam int PSUM_DEPTH      = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } drain_state_e;

endpackage

// File: rtl/psum_skid_fifo.sv
// Two-entry FIFO used to absorb read latency and consumer stalls.
// Latency: a pushed word is visible at head one clk after the push edge.
// Backpressure: full/empty are reported; push while full is taken only with a pop.
module psum_skid_fifo #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            occ,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (occ == 2'd2);
  assign empty   = (occ == 2'd0);
  // a full buffer still accepts a push when the head leaves on the same edge
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // storage, pointers and occupancy; everything moves on the falling edge
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/psum_drain.sv
// Reads len psum words from the spad starting at base_addr and streams them out.
// Latency: first out_valid 3 falling edges after start; one word/cycle with out_ready high.
// Backpressure: reads are issued only when a buffer slot is guaranteed; stalls hold out_data.
module psum_drain
  import psum_drain_pkg::*;
#(
  parameter int DATA_WIDTH = PSUM_DATA_WIDTH,
  parameter int ADDR_WIDTH = PSUM_ADDR_WIDTH,
  parameter int DEPTH      = PSUM_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int            CW      = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  drain_state_e          state;
  drain_state_e          state_nxt;

  logic [ADDR_WIDTH-1:0] base_q;
  logic [CW-1:0]         len_q;
  logic [CW-1:0]         issue_cnt;
  logic [CW-1:0]         sent_cnt;
  logic                  inflight;

  logic [CW-1:0]         len_clamped;
  logic [ADDR_WIDTH-1:0] base_norm;
  logic [CW-1:0]         addr_sum;
  logic [2:0]            pending;
  logic                  slot_ok;
  logic                  pop;
  logic                  last_pop;

  logic [1:0]            buf_occ;
  logic                  buf_full;
  logic                  buf_empty;

  // oversize requests drain the whole spad once
  assign len_clamped = (len > DEPTH_C) ? DEPTH_C : len;
  // fold an out-of-range base back into the spad so one subtract wraps rd_addr
  assign base_norm   = ({1'b0, base_addr} >= DEPTH_C) ? (base_addr - ADDR_WIDTH'(DEPTH)) : base_addr;

  assign addr_sum  = {1'b0, base_q} + issue_cnt;
  assign rd_addr   = (addr_sum >= DEPTH_C) ? ADDR_WIDTH'(addr_sum - DEPTH_C) : addr_sum[ADDR_WIDTH-1:0];

  assign out_valid = !buf_empty;
  assign pop       = out_valid && out_ready;
  assign last_pop  = pop && ((sent_cnt + 1'b1) == len_q);

  // words already committed to the buffer: held plus the one still in the spad pipe;
  // a pop this cycle frees a slot for the next read
  assign pending = {1'b0, buf_occ} + {2'b00, inflight};
  assign slot_ok = pending < (3'd2 + {2'b00, pop});

  psum_skid_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .push     (inflight),
    .push_data(rd_data),
    .pop      (pop),
    .head     (out_data),
    .occ      (buf_occ),
    .full     (buf_full),
    .empty    (buf_empty)
  );

  // state register
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state: a zero-length drain still reports completion
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = (len_clamped == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_pop) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // outputs: read strobe only in RUN with words left and a slot guaranteed
  always_comb begin
    rd_en = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      ST_RUN: begin
        busy  = 1'b1;
        rd_en = (issue_cnt < len_q) && slot_ok;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // request latch, issue/sent counters and the one-cycle read-in-flight flag
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      base_q    <= '0;
      len_q     <= '0;
      issue_cnt <= '0;
      sent_cnt  <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= rd_en;
      if ((state == ST_IDLE) && start) begin
        base_q    <= base_norm;
        len_q     <= len_clamped;
        issue_cnt <= '0;
        sent_cnt  <= '0;
      end else begin
        if (rd_en) begin
          issue_cnt <= issue_cnt + 1'b1;
        end
        if (pop && (state == ST_RUN)) begin
          sent_cnt <= sent_cnt + 1'b1;
        end
      end
    end
  end

  // a returning read must always find room in the buffer
  a_no_overflow: assert property (@(negedge clk) disable iff (!reset) !(inflight && buf_full && !pop));

endmodule

// File: tb/tb_psum_drain.sv
// Bench for psum_drain: spad model, directed table, hand-written corner sequences, random drains.
// Latency: n/a.
// Backpressure: out_ready driven by fixed, patterned or random schedules.
module tb_psum_drain;
  import psum_drain_pkg::*;

  localparam int DW    = PSUM_DATA_WIDTH;
  localparam int AW    = PSUM_ADDR_WIDTH;
  localparam int DEPTH = PSUM_DEPTH;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  psum_drain dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .base_addr(base_addr),
    .len      (len),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done)
  );

  // spad model: data appears one falling edge after the read strobe
  logic [DW-1:0] spad [DEPTH];
  always @(negedge clk) if (rd_en) rd_data <= spad[rd_addr];

  // scoreboard state
  int            vectors = 0;
  int            miscompares = 0;
  int            cur_base, cur_n, issued, accepted, done_cnt;
  int            first_word, last_word;
  logic [DW-1:0] expq[$];
  bit            stall_prev;
  logic [DW-1:0] stall_data;

  typedef struct {
    int base; int len; int mode;
    int words; int first; int last; int busy_cyc; int lat;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic rdy(input int mode, input int idx);
    logic [5:0] p;
    p = 6'b101001;
    case (mode)
      0:       return 1'b1;
      1:       return p[idx % 6];
      2:       return $urandom_range(0, 1) == 1;
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  // sample the cycle, check it against the model, then advance one clock
  task automatic tick();
    bit pop;
    #1;
    pop = out_valid && out_ready;
    if (rd_en) begin
      chk("rd_addr", int'(rd_addr), (cur_base + issued) % DEPTH);
      chk("rd_en_slot", int'((issued - accepted - int'(pop)) < 2), 1);
      chk("rd_en_count", int'(issued < cur_n), 1);
      issued++;
    end
    if (stall_prev) begin
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_data", int'(out_data), int'(stall_data));
    end
    if (pop) begin
      if (expq.size() == 0) chk("extra_word", accepted + 1, cur_n);
      else chk("out_data", int'(out_data), int'(expq.pop_front()));
      if (accepted == 0) first_word = int'(out_data);
      last_word = int'(out_data);
      accepted++;
    end
    stall_prev = out_valid && !out_ready;
    stall_data = out_data;
    if (done) done_cnt++;
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic arm_model(input int b, input int n);
    cur_base = b; cur_n = n; issued = 0; accepted = 0;
    first_word = -1; last_word = -1;
    expq.delete();
    for (int i = 0; i < n; i++) expq.push_back(spad[(b + i) % DEPTH]);
  endtask

  task automatic run_drain(input int b, input int l, input int mode,
                           output int busy_cyc, output int lat);
    int n, d0, k;
    n  = (l > DEPTH) ? DEPTH : l;
    d0 = done_cnt;
    arm_model(b, n);
    start = 1'b1; base_addr = AW'(b); len = (AW+1)'(l);
    out_ready = rdy(mode, 0);
    tick();
    start = 1'b0;
    k = 1; lat = -1;
    while (busy && k <= 400) begin
      if (out_valid && lat < 0) lat = k;
      out_ready = rdy(mode, k);
      tick();
      k++;
    end
    busy_cyc = k - 1;
    chk("drain_end_busy", int'(busy), 0);
    chk("words", accepted, n);
    chk("done_pulses", done_cnt - d0, 1);
  endtask

  initial begin
    int bc, lat, d0, starts, k, b, l;
    reset = 1'b0; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b0;
    rd_data = '0; done_cnt = 0; stall_prev = 1'b0; stall_data = '0;
    for (int i = 0; i < DEPTH; i++) spad[i] = DW'(100 + i);
    arm_model(0, 0);
    #1;
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    repeat (2) @(posedge clk);
    reset = 1'b1;
    @(posedge clk);

    // directed table: base, len, ready mode, words, first, last, busy cycles, first-valid latency
    tbl[0] = '{0,  4,  0, 4,  100, 103, 7,  3};
    tbl[1] = '{22, 4,  0, 4,  122, 101, 7,  3};
    tbl[2] = '{5,  1,  0, 1,  105, 105, 4,  3};
    tbl[3] = '{0,  0,  0, 0,  -1,  -1,  1,  -1};
    tbl[4] = '{10, 24, 0, 24, 110, 109, 27, 3};
    tbl[5] = '{3,  31, 0, 24, 103, 102, 27, 3};
    tbl[6] = '{7,  6,  1, 6,  107, 112, -1, 3};
    for (int i = 0; i < 7; i++) begin
      run_drain(tbl[i].base, tbl[i].len, tbl[i].mode, bc, lat);
      chk("tbl_words", accepted, tbl[i].words);
      chk("tbl_first", first_word, tbl[i].first);
      chk("tbl_last", last_word, tbl[i].last);
      chk("tbl_latency", lat, tbl[i].lat);
      if (tbl[i].busy_cyc >= 0) chk("tbl_busy_cycles", bc, tbl[i].busy_cyc);
    end

    // zero-length drain with a second start arriving while busy
    arm_model(0, 0);
    d0 = done_cnt;
    start = 1'b1; base_addr = '0; len = '0;
    tick();
    chk("len0_busy", int'(busy), 1);
    chk("len0_done", int'(done), 1);
    base_addr = AW'(3); len = (AW+1)'(4);
    tick();
    start = 1'b0;
    chk("len0_idle", int'(busy), 0);
    repeat (4) tick();
    chk("len0_ignored_start", int'(busy), 0);
    chk("len0_done_count", done_cnt - d0, 1);

    // reset pulled during word 3 of an 8-word drain
    arm_model(0, 8);
    start = 1'b1; base_addr = '0; len = (AW+1)'(8); out_ready = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (accepted < 3 && k < 50) begin tick(); k++; end
    chk("pre_reset_words", accepted, 3);
    reset = 1'b0;
    #1;
    chk("mid_rst_rd_en", int'(rd_en), 0);
    chk("mid_rst_rd_addr", int'(rd_addr), 0);
    chk("mid_rst_out_data", int'(out_data), 0);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    arm_model(0, 0);
    stall_prev = 1'b0;
    d0 = done_cnt;
    repeat (2) tick();
    reset = 1'b1;
    repeat (4) tick();
    chk("post_rst_no_done", done_cnt - d0, 0);
    chk("post_rst_idle", int'(busy), 0);
    run_drain(0, 2, 0, bc, lat);
    chk("post_rst_first", first_word, 100);
    chk("post_rst_last", last_word, 101);

    // random drains over random spad contents and random back-pressure
    for (int i = 0; i < DEPTH; i++) spad[i] = DW'($urandom_range(0, 65535));
    d0 = done_cnt;
    starts = 0;
    for (int i = 0; i < 1000; i++) begin
      b = $urandom_range(0, DEPTH - 1);
      l = ($urandom_range(0, 9) == 0) ? 31 : $urandom_range(0, DEPTH);
      run_drain(b, l, $urandom_range(0, 3), bc, lat);
      starts++;
    end
    chk("done_vs_start", done_cnt - d0, starts);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
